// File: rtl/bdpu_pkg.sv
// Shared types and helpers for the BRAM sequencer.
// Default widths match the banked BRAM instance.
package bdpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int VAR_W  = 32;
    localparam int ADD_W  = 10;
    localparam int PIPE_W = 16;
    localparam int PLOG   = $clog2(PIPE_W);

    // BRAM control bundle field widths
    localparam int CS_W  = 1;
    localparam int WE_W  = 1;
    localparam int OE_W  = PIPE_W;
    localparam int ADD_F = ADD_W;
    localparam int DIN_F = VAR_W;

    function automatic int plog_of(input int pw);
        return $clog2(pw);
    endfunction

endpackage

// File: rtl/bram_addr_gen.sv
// Load address generator: latched base/len, word count,
// wrapping address adder and last-word compare.
module bram_addr_gen #(
    parameter int ADD_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [ADD_WIDTH-1:0] base_in,
    input  logic [ADD_WIDTH:0]   len_in,
    output logic [ADD_WIDTH-1:0] addr,
    output logic                 last
);

    logic [ADD_WIDTH-1:0] base_q, base_d;
    logic [ADD_WIDTH:0]   len_q, len_d;
    logic [ADD_WIDTH:0]   cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (start) begin
            base_d = base_in;
            len_d  = len_in;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // dropping the count MSB gives the modulo-2^ADD_WIDTH wrap
    assign addr = base_q + cnt_q[ADD_WIDTH-1:0];
    assign last = (cnt_q == len_q - 1'b1);

endmodule

// File: rtl/bram_seq.sv
// Arbitrates a serial word-load stream and wide row reads
// onto the single BRAM port set; returns row data with a strobe.
module bram_seq
    import bdpu_pkg::*;
#(
    parameter int varWIDTH   = 32,
    parameter int ADD_WIDTH  = 10,
    parameter int PIPE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic [ADD_WIDTH-1:0]           load_base,
    input  logic [ADD_WIDTH:0]             load_len,
    input  logic                           wr_valid,
    input  logic [varWIDTH-1:0]            wr_data,
    output logic                           wr_ready,
    output logic                           load_done,
    output logic                           busy,
    input  logic                           rd_req,
    input  logic [ADD_WIDTH-plog_of(PIPE_WIDTH)-1:0] rd_row,
    input  logic [PIPE_WIDTH-1:0]          rd_mask,
    output logic                           rd_gnt,
    output logic                           rd_valid,
    output logic [varWIDTH*PIPE_WIDTH-1:0] rd_data,
    output logic [ADD_WIDTH-1:0]           bram_add,
    output logic [varWIDTH-1:0]            bram_din,
    output logic                           bram_cs,
    output logic                           bram_we,
    output logic [PIPE_WIDTH-1:0]          bram_oe,
    input  logic [varWIDTH*PIPE_WIDTH-1:0] bram_dout
);

    localparam int RPLOG = plog_of(PIPE_WIDTH);

    seq_state_e state_q, state_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  rv_q, rv_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic [PIPE_WIDTH-1:0] oe_q, oe_d;
    logic [ADD_WIDTH-1:0]  add_q, add_d;
    logic [varWIDTH-1:0]   din_q, din_d;

    logic                 in_idle, in_load;
    logic                 wr_hs, start_go;
    logic [ADD_WIDTH-1:0] gen_addr;
    logic                 gen_last;

    assign in_idle  = (state_q == IDLE);
    assign in_load  = (state_q == LOAD);
    assign wr_hs    = in_load && wr_valid;
    assign start_go = in_idle && load_start && (load_len != '0);

    assign wr_ready = in_load;
    // a pending write always wins; start wins in IDLE
    assign rd_gnt   = !rst && rd_req &&
                      ((in_idle && !load_start) || (in_load && !wr_valid));

    bram_addr_gen #(
        .ADD_WIDTH(ADD_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (start_go),
        .step    (wr_hs),
        .base_in (load_base),
        .len_in  (load_len),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = '0;
        add_d   = add_q;
        din_d   = din_q;
        rv_d    = cs_q && !we_q;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (wr_hs && gen_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_hs) begin
            cs_d  = 1'b1;
            we_d  = 1'b1;
            add_d = gen_addr;
            din_d = wr_data;
        end else if (rd_gnt) begin
            cs_d  = 1'b1;
            add_d = {rd_row, {RPLOG{1'b0}}};
            oe_d  = rd_mask;
        end

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= '0;
            add_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            add_q   <= add_d;
            din_q   <= din_d;
        end
    end

    assign load_done = done_q;
    assign busy      = busy_q;
    assign rd_valid  = rv_q;
    assign rd_data   = bram_dout;
    assign bram_cs   = cs_q;
    assign bram_we   = we_q;
    assign bram_oe   = oe_q;
    assign bram_add  = add_q;
    assign bram_din  = din_q;

endmodule

// File: tb/tb_bram_seq.sv
// Bench for bram_seq: BRAM behavioural model, per-cycle
// scoreboard of port activity and read data, literal spot checks.
module tb_bram_seq;

    localparam int VW = 32;
    localparam int AW = 10;
    localparam int PW = 16;
    localparam int PL = 4;
    localparam int RW = AW - PL;
    localparam int DW = VW * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic          wr_valid = 1'b0;
    logic [VW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          load_done;
    logic          busy;
    logic          rd_req = 1'b0;
    logic [RW-1:0] rd_row = '0;
    logic [PW-1:0] rd_mask = '0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] bram_add;
    logic [VW-1:0] bram_din;
    logic          bram_cs;
    logic          bram_we;
    logic [PW-1:0] bram_oe;
    logic [DW-1:0] bram_dout;

    bram_seq #(
        .varWIDTH   (VW),
        .ADD_WIDTH  (AW),
        .PIPE_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .load_done  (load_done),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_row     (rd_row),
        .rd_mask    (rd_mask),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .bram_add   (bram_add),
        .bram_din   (bram_din),
        .bram_cs    (bram_cs),
        .bram_we    (bram_we),
        .bram_oe    (bram_oe),
        .bram_dout  (bram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: synchronous write, registered masked row read
    logic [VW-1:0] bmem [0:1023];
    always @(posedge clk) begin
        if (bram_cs) begin
            if (bram_we) bmem[bram_add] <= bram_din;
            else
                for (int i = 0; i < PW; i++)
                    bram_dout[i*VW +: VW] <= bram_oe[i] ?
                        bmem[int'(bram_add) + i] : '0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected per-cycle activity: {cs,we,rv,done,busy,oe[15:0]}
    logic [20:0]   e_ctl [int];
    logic [AW-1:0] e_add [int];
    logic [VW-1:0] e_din [int];
    logic [DW-1:0] e_rd  [int];
    logic [DW-1:0] rdh   [int];
    logic [VW-1:0] ref_mem [0:1023];

    task automatic set_ctl(input int c, input logic [20:0] v);
        if (e_ctl.exists(c)) e_ctl[c] = e_ctl[c] | v;
        else e_ctl[c] = v;
    endtask

    always @(negedge clk) begin : cmp
        logic [20:0] ex;
        ex = e_ctl.exists(cyc) ? e_ctl[cyc] : 21'h0;
        chk("ctl", DW'({bram_cs, bram_we, rd_valid, load_done, busy, bram_oe}),
            DW'(ex));
        if (ex[20]) chk("bram_add", DW'(bram_add), DW'(e_add[cyc]));
        if (ex[20] && ex[19]) chk("bram_din", DW'(bram_din), DW'(e_din[cyc]));
        if (ex[18]) chk("rd_data", rd_data, e_rd[cyc]);
    end

    // Model: 0 idle, 1 loading, 2 zero-length done
    int m_st = 0;
    int m_base = 0;
    int m_len = 0;
    int m_cnt = 0;

    task automatic step(input logic st, input int b, input int l,
                        input logic wv, input logic [VW-1:0] wd,
                        input logic rq, input int row, input logic [PW-1:0] mk);
        int c, nst, a;
        logic hs, eg;
        logic [DW-1:0] rv;
        load_start = st;
        load_base  = AW'(b);
        load_len   = (AW+1)'(l);
        wr_valid   = wv;
        wr_data    = wd;
        rd_req     = rq;
        rd_row     = RW'(row);
        rd_mask    = mk;
        @(negedge clk);
        c = cyc;
        rdh[c] = rd_data;
        hs = (m_st == 1) && wv;
        eg = rq && ((m_st == 0 && !st) || (m_st == 1 && !wv));
        chk("wr_ready", DW'(wr_ready), DW'(m_st == 1));
        chk("rd_gnt", DW'(rd_gnt), DW'(eg));
        nst = m_st;
        if (hs) begin
            a = (m_base + m_cnt) % 1024;
            ref_mem[a] = wd;
            set_ctl(c + 1, 21'h180000);
            e_add[c + 1] = AW'(a);
            e_din[c + 1] = wd;
            m_cnt++;
            if (m_cnt == m_len) begin
                nst = 0;
                set_ctl(c + 1, 21'h020000);
            end
        end else if (eg) begin
            a = row * PW;
            set_ctl(c + 1, {5'b10000, mk});
            e_add[c + 1] = AW'(a);
            for (int i = 0; i < PW; i++)
                rv[i*VW +: VW] = mk[i] ? ref_mem[a + i] : '0;
            set_ctl(c + 2, 21'h040000);
            e_rd[c + 2] = rv;
        end
        if (m_st == 0 && st) begin
            if (l == 0) begin
                nst = 2;
                set_ctl(c + 1, 21'h020000);
            end else begin
                nst = 1;
                m_base = b;
                m_len = l;
                m_cnt = 0;
            end
        end else if (m_st == 2) begin
            nst = 0;
        end
        if (nst == 1) set_ctl(c + 1, 21'h010000);
        m_st = nst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic rd(input int row, input logic [PW-1:0] mk);
        step(0, 0, 0, 0, '0, 1, row, mk);
    endtask

    task automatic run_load(input int b, input int l, input logic [VW-1:0] d0);
        step(1, b, l, 0, '0, 0, 0, '0);
        for (int i = 0; i < l; i++) step(0, 0, 0, 1, d0 + VW'(i), 0, 0, '0);
    endtask

    task automatic do_reset(input int n);
        load_start = 1'b1;
        wr_valid   = 1'b1;
        rd_req     = 1'b1;
        rst        = 1'b1;
        #1;
        chk("rst_outs", DW'({bram_cs, bram_we, bram_oe, rd_valid, load_done,
                             busy, wr_ready, rd_gnt, bram_add, bram_din}), '0);
        for (int k = cyc; k < cyc + 4; k++) begin
            if (e_ctl.exists(k)) e_ctl.delete(k);
        end
        m_st = 0;
        m_cnt = 0;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        rd_req     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [VW-1:0] lane(input logic [DW-1:0] d, input int i);
        return d[i*VW +: VW];
    endfunction

    initial begin
        int rc;
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = '0;
            ref_mem[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset(3);
        idle(5);

        // wrap-around load, then rows 63 and 0
        run_load(10'h3F0, 32, 32'd0);
        idle(1);
        rc = cyc;
        rd(63, 16'hFFFF);
        rd(0, 16'hFFFF);
        idle(3);
        chk("row63_l0", DW'(lane(rdh[rc + 2], 0)), DW'(32'd0));
        chk("row63_l15", DW'(lane(rdh[rc + 2], 15)), DW'(32'd15));
        chk("row0_l0", DW'(lane(rdh[rc + 3], 0)), DW'(32'd16));
        chk("row0_l15", DW'(lane(rdh[rc + 3], 15)), DW'(32'd31));

        // masked read of row 5
        run_load(80, 16, 32'hA0);
        rc = cyc;
        rd(5, 16'h00FF);
        idle(3);
        chk("row5_l3", DW'(lane(rdh[rc + 2], 3)), DW'(32'hA3));
        chk("row5_l8", DW'(lane(rdh[rc + 2], 8)), DW'(32'h0));

        // start beats read; reads fill write gaps; start in LOAD ignored
        step(1, 200, 6, 0, '0, 1, 12, 16'hFFFF);
        step(0, 0, 0, 1, 32'h1000, 1, 12, 16'hFFFF);
        step(0, 0, 0, 0, '0, 1, 12, 16'hFFFF);
        step(1, 0, 3, 1, 32'h1001, 1, 12, 16'hFFFF);
        step(0, 0, 0, 1, 32'h1002, 1, 12, 16'hFFFF);
        step(0, 0, 0, 0, '0, 1, 12, 16'hFFFF);
        step(0, 0, 0, 0, '0, 1, 12, 16'hFFFF);
        step(0, 0, 0, 1, 32'h1003, 1, 12, 16'hFFFF);
        step(0, 0, 0, 1, 32'h1004, 1, 12, 16'hFFFF);
        step(0, 0, 0, 1, 32'h1005, 1, 12, 16'hFFFF);
        rc = cyc;
        rd(12, 16'hFFFF);
        rd(0, 16'hFFFF);
        idle(3);
        chk("row12_l8", DW'(lane(rdh[rc + 2], 8)), DW'(32'h1000));
        chk("row12_l13", DW'(lane(rdh[rc + 2], 13)), DW'(32'h1005));

        // zero-length load; start during DONE ignored
        step(1, 55, 0, 0, '0, 0, 0, '0);
        step(1, 77, 5, 0, '0, 0, 0, '0);
        idle(3);

        // reset after 7 of 20 words with a read in flight
        step(1, 300, 20, 0, '0, 0, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 32'h7000 + VW'(i), 0, 0, '0);
        step(0, 0, 0, 0, '0, 1, 18, 16'hFFFF);
        do_reset(2);
        idle(2);
        rd(18, 16'hFFFF);
        rd(19, 16'hFFFF);
        idle(2);
        run_load(300, 20, 32'h8000);
        rd(18, 16'hFFFF);
        rd(19, 16'hF0F0);
        idle(3);

        // full-array load from 0x200, then read back every row
        run_load(10'h200, 1024, 32'h5A5A0000);
        rc = cyc;
        for (int r = 0; r < 64; r++) rd(r, 16'hFFFF);
        idle(3);
        chk("full_r31_l15", DW'(lane(rdh[rc + 33], 15)), DW'(32'h5A5A03FF));
        chk("full_r32_l0", DW'(lane(rdh[rc + 34], 0)), DW'(32'h5A5A0000));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_seq.md
# bram_seq

Sequencer and arbiter for the banked `BRAM` array. It accepts a serial word-load stream (base address, length, valid/ready data) and single-row wide-read requests. It arbitrates the two onto the BRAM's single `add`/`cs`/`we`/`oe` port set and returns row data with a valid strobe. It sits between the layer loader / PE row fetch logic and one `BRAM` instance of matching parameters.

## Interface
- `varWIDTH`, 32, bits per word
- `ADD_WIDTH`, 10, BRAM word-address width
- `PIPE_WIDTH`, 16, words per row (power of 2); `PLOG` = log2(PIPE_WIDTH)

Ports (`clk` and `rst` first):
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_start`  in  1  start a load; sampled only in IDLE
- `load_base`  in  ADD_WIDTH  first word address of the load
- `load_len`  in  ADD_WIDTH+1  number of words to load, 0..2^ADD_WIDTH
- `wr_valid`  in  1  load word present
- `wr_data`  in  varWIDTH  load word
- `wr_ready`  out  1  word accepted when `wr_valid && wr_ready`
- `load_done`  out  1  one-cycle pulse when the last word of a load is accepted
- `busy`  out  1  high while in LOAD
- `rd_req`  in  1  row read request; held until granted
- `rd_row`  in  ADD_WIDTH-PLOG  row index
- `rd_mask`  in  PIPE_WIDTH  lane output-enable mask
- `rd_gnt`  out  1  combinational grant; request consumed this cycle
- `rd_valid`  out  1  `rd_data` valid
- `rd_data`  out  varWIDTH*PIPE_WIDTH  row data, passthrough of `bram_dout`
- `bram_add`, `bram_din`, `bram_cs`, `bram_we`, `bram_oe`  out  ADD_WIDTH / varWIDTH / 1 / 1 / PIPE_WIDTH  registered BRAM controls
- `bram_dout`  in  varWIDTH*PIPE_WIDTH  BRAM `data_out`

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - `load_start` with `load_len`≠0 → LOAD. Latch base, len; clear the count.
  - `load_start` with `load_len`=0 → DONE (no writes).
  - `load_start` has priority over a simultaneous `rd_req`.
  - Otherwise `rd_req` → `rd_gnt`=1.
- LOAD:
  - `wr_ready`=1.
  - On a handshake, issue a write at address (base+count) mod 2^ADD_WIDTH, then count++.
  - Reads interleave opportunistically: `rd_gnt` = `rd_req && !wr_valid`. A write always beats a read in the same cycle.
  - On the handshake with count = len-1: `load_done`=1, next state IDLE.
- DONE: `load_done`=1 for one cycle, then IDLE. Used only for len=0.
- `load_start` outside IDLE is ignored.
- Write issue, registered for the next cycle: `bram_cs`=1, `bram_we`=1, `bram_add`=address, `bram_din`=`wr_data`, `bram_oe`=0.
- Read issue, registered for the next cycle: `bram_cs`=1, `bram_we`=0, `bram_add`={`rd_row`, PLOG'b0}, `bram_oe`=`rd_mask`.
- Idle cycle: `bram_cs`=`bram_we`=0 and `bram_oe`=0. `bram_add` and `bram_din` hold their values.
- `rd_data` = `bram_dout`. Masked lanes read 0 by BRAM behaviour.

## Timing
- Reset values: `bram_add`=0, `bram_din`=0, `bram_cs`=0, `bram_we`=0, `bram_oe`=0, `rd_valid`=0, `load_done`=0, `busy`=0; state IDLE, count 0.
- `wr_ready` and `rd_gnt` are combinational from state and inputs, so both are 0 during reset.
- Write latency: handshake in cycle N → BRAM ports driven in N+1 → memory updated at the end of N+1.
- Read latency: `rd_gnt` in cycle N → ports in N+1 → `rd_valid`=1 with data in N+2. Full throughput: one read per cycle in IDLE.
- Read-after-write: a read granted in any cycle after the final write handshake returns the new data. No hazard stall is needed.
- Address wrap: base+count wraps modulo 2^ADD_WIDTH. len = 2^ADD_WIDTH writes every word exactly once.
- `rst` mid-load: the load is abandoned and no `load_done` is produced. An in-flight `rd_valid` is dropped. Memory contents written so far remain.

## Structure
- Shared package `bdpu_pkg`:
  - state enum {IDLE, LOAD, DONE}
  - `clog2`-derived `PLOG`
  - BRAM control bundle field widths
- Optional sub-module `bram_addr_gen`: latched base, count, wrap adder, last-word compare. Everything else stays flat in `bram_seq`.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `wr_ready`=0.
- Load base=0x3F0, len=32, PIPE_WIDTH=16, continuous `wr_valid`, data=i → writes to 0x3F0..0x3FF, then wrap to 0x000..0x00F. `load_done` on the 32nd handshake. Reading rows 63 and 0 returns 0..15 and 16..31.
- `rd_req` row 5 with mask 0x00FF, in IDLE → `rd_gnt` same cycle, `rd_valid` two cycles later. Lanes 8–15 are 0, lanes 0–7 hold the stored words.
- `load_start` and `rd_req` in the same cycle → load wins, `rd_gnt`=0. During LOAD with a `wr_valid` gap, `rd_gnt`=1 exactly in the gap cycles, with correct data.
- `load_len`=0 → `load_done` pulse one cycle after start, no `bram_we`. `load_start` asserted during LOAD → ignored, count unaffected.
- `rst` asserted after 7 of 20 words → all outputs 0 immediately, state IDLE. A new load after reset completes normally.
